// File: rtl/fu_run_ctrl.sv
// -----------------------------------------------------------------------------
// fu_run_ctrl
//   Run controller for a bank of N_FU functional units.
//   - It initialises the units for INIT_CYC cycles.
//   - It runs cfg_len enabled iterations. Downstream stall freezes an iteration.
//   - It drains the pipeline for PIPE_DEPTH cycles.
//   - It pulses done once.
//   A start with a zero length is rejected with a one-cycle err pulse.
//   abort returns the block to IDLE from any busy state.
//
// Ports
//   fu_run_ctrl_clk         in   clock, rising edge
//   fu_run_ctrl_reset       in   asynchronous active-low reset
//   fu_run_ctrl_start       in   run request (sampled in IDLE only)
//   fu_run_ctrl_abort       in   terminate the run on the next edge
//   fu_run_ctrl_stall       in   backpressure; the next RUN cycle is not enabled
//   fu_run_ctrl_cfg_len     in   number of enabled iterations (latched on start)
//   fu_run_ctrl_cfg_mask    in   per-unit enable mask (latched on start)
//   fu_run_ctrl_fu_init     out  broadcast init to all units
//   fu_run_ctrl_fu_disable  out  per-unit disable (all-ones unless enabled)
//   fu_run_ctrl_busy        out  high in INIT, RUN and DRAIN
//   fu_run_ctrl_done        out  one-cycle completion pulse
//   fu_run_ctrl_err         out  one-cycle pulse on a rejected start
//   fu_run_ctrl_iter_cnt    out  completed enabled iterations
//
// Timing model
//   - All outputs are registered. Each one is computed from the state being
//     entered on an edge.
//   - An enabled RUN cycle is decided at the edge that opens it, from stall at
//     that edge.
//   - The iteration is counted at the edge that closes it.
//   - As a result, iter_cnt counts only iterations that finished.
//   - An abort discards the iteration in flight.
// -----------------------------------------------------------------------------
module fu_run_ctrl #(
   parameter int CNT_W      = 16,
   parameter int N_FU       = 4,
   parameter int INIT_CYC   = 1,
   parameter int PIPE_DEPTH = 2
) (
   input  logic             fu_run_ctrl_clk,
   input  logic             fu_run_ctrl_reset,
   input  logic             fu_run_ctrl_start,
   input  logic             fu_run_ctrl_abort,
   input  logic             fu_run_ctrl_stall,
   input  logic [CNT_W-1:0] fu_run_ctrl_cfg_len,
   input  logic [N_FU-1:0]  fu_run_ctrl_cfg_mask,
   output logic             fu_run_ctrl_fu_init,
   output logic [N_FU-1:0]  fu_run_ctrl_fu_disable,
   output logic             fu_run_ctrl_busy,
   output logic             fu_run_ctrl_done,
   output logic             fu_run_ctrl_err,
   output logic [CNT_W-1:0] fu_run_ctrl_iter_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // The phase counter is shared by INIT and DRAIN. Both lengths are limited
   // to 1..15, so four bits are enough.
   localparam logic [3:0] INIT_LAST  = 4'(INIT_CYC - 1);
   localparam logic [3:0] DRAIN_LAST = 4'(PIPE_DEPTH - 1);

   state_t           state_q, state_d;
   logic [3:0]       phase_q, phase_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [N_FU-1:0]  mask_q, mask_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic             en_q, en_d;          // current RUN cycle is an enabled iteration
   logic             fu_init_q, fu_init_d;
   logic [N_FU-1:0]  fu_disable_q, fu_disable_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] iter_inc;

   // The counter never exceeds len_q. Its increment therefore cannot overflow,
   // even when len_q is 2^CNT_W-1.
   assign iter_inc = iter_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      len_d   = len_q;
      mask_d  = mask_q;
      iter_d  = iter_q;
      en_d    = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // abort together with start silently rejects the start.
            if (fu_run_ctrl_start && !fu_run_ctrl_abort) begin
               if (fu_run_ctrl_cfg_len != '0) begin
                  state_d = ST_INIT;
                  len_d   = fu_run_ctrl_cfg_len;
                  mask_d  = fu_run_ctrl_cfg_mask;
                  iter_d  = '0;
                  phase_d = 4'd0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_INIT: begin
            if (fu_run_ctrl_abort) begin
               state_d = ST_IDLE;
            end else if (phase_q == INIT_LAST) begin
               state_d = ST_RUN;
               en_d    = !fu_run_ctrl_stall;
               phase_d = 4'd0;
            end else begin
               phase_d = phase_q + 4'd1;
            end
         end

         ST_RUN: begin
            if (fu_run_ctrl_abort) begin
               state_d = ST_IDLE;
            end else begin
               if (en_q) begin
                  iter_d = iter_inc;
               end
               if (en_q && (iter_inc == len_q)) begin
                  state_d = ST_DRAIN;
                  phase_d = 4'd0;
               end else begin
                  en_d = !fu_run_ctrl_stall;
               end
            end
         end

         ST_DRAIN: begin
            if (fu_run_ctrl_abort) begin
               state_d = ST_IDLE;
            end else if (phase_q == DRAIN_LAST) begin
               state_d = ST_DONE;
            end else begin
               phase_d = phase_q + 4'd1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registered outputs follow the state being entered.
      fu_init_d    = (state_d == ST_INIT);
      busy_d       = (state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d       = (state_d == ST_DONE);
      fu_disable_d = en_d ? ~mask_d : '1;
   end

   always_ff @(posedge fu_run_ctrl_clk or negedge fu_run_ctrl_reset) begin
      if (!fu_run_ctrl_reset) begin
         state_q      <= ST_IDLE;
         phase_q      <= 4'd0;
         len_q        <= '0;
         mask_q       <= '0;
         iter_q       <= '0;
         en_q         <= 1'b0;
         fu_init_q    <= 1'b0;
         fu_disable_q <= '1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         len_q        <= len_d;
         mask_q       <= mask_d;
         iter_q       <= iter_d;
         en_q         <= en_d;
         fu_init_q    <= fu_init_d;
         fu_disable_q <= fu_disable_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign fu_run_ctrl_fu_init    = fu_init_q;
   assign fu_run_ctrl_fu_disable = fu_disable_q;
   assign fu_run_ctrl_busy       = busy_q;
   assign fu_run_ctrl_done       = done_q;
   assign fu_run_ctrl_err        = err_q;
   assign fu_run_ctrl_iter_cnt   = iter_q;

endmodule

// File: tb/tb_fu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fu_run_ctrl
//   Self-checking bench for fu_run_ctrl.
//   - Instance a uses the default parameters.
//   - Instance b uses CNT_W=4 and INIT_CYC=3 for the no-wrap and latency case.
//
//   Stimulus:
//   - Each vector drives its inputs on the falling edge before a rising edge.
//   - Outputs are checked 1 ns after that edge.
//   - The value checked after edge k belongs to cycle k+1.
// -----------------------------------------------------------------------------
module tb_fu_run_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b1;

   // Instance a: default parameters
   logic        a_start = 1'b0, a_abort = 1'b0, a_stall = 1'b0;
   logic [15:0] a_len   = '0;
   logic [3:0]  a_mask  = '0;
   logic        a_fu_init, a_busy, a_done, a_err;
   logic [3:0]  a_fu_disable;
   logic [15:0] a_iter;

   // Instance b: narrow counter, longer init
   logic        b_start = 1'b0, b_abort = 1'b0, b_stall = 1'b0;
   logic [3:0]  b_len   = '0;
   logic [3:0]  b_mask  = '0;
   logic        b_fu_init, b_busy, b_done, b_err;
   logic [3:0]  b_fu_disable;
   logic [3:0]  b_iter;

   fu_run_ctrl dut_a (
      .fu_run_ctrl_clk        (clk),
      .fu_run_ctrl_reset      (rst_n),
      .fu_run_ctrl_start      (a_start),
      .fu_run_ctrl_abort      (a_abort),
      .fu_run_ctrl_stall      (a_stall),
      .fu_run_ctrl_cfg_len    (a_len),
      .fu_run_ctrl_cfg_mask   (a_mask),
      .fu_run_ctrl_fu_init    (a_fu_init),
      .fu_run_ctrl_fu_disable (a_fu_disable),
      .fu_run_ctrl_busy       (a_busy),
      .fu_run_ctrl_done       (a_done),
      .fu_run_ctrl_err        (a_err),
      .fu_run_ctrl_iter_cnt   (a_iter)
   );

   fu_run_ctrl #(.CNT_W(4), .N_FU(4), .INIT_CYC(3), .PIPE_DEPTH(2)) dut_b (
      .fu_run_ctrl_clk        (clk),
      .fu_run_ctrl_reset      (rst_n),
      .fu_run_ctrl_start      (b_start),
      .fu_run_ctrl_abort      (b_abort),
      .fu_run_ctrl_stall      (b_stall),
      .fu_run_ctrl_cfg_len    (b_len),
      .fu_run_ctrl_cfg_mask   (b_mask),
      .fu_run_ctrl_fu_init    (b_fu_init),
      .fu_run_ctrl_fu_disable (b_fu_disable),
      .fu_run_ctrl_busy       (b_busy),
      .fu_run_ctrl_done       (b_done),
      .fu_run_ctrl_err        (b_err),
      .fu_run_ctrl_iter_cnt   (b_iter)
   );

   typedef struct {
      logic        start;
      logic        abort;
      logic        stall;
      logic [15:0] len;
      logic [3:0]  mask;
      logic [23:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   n_pass  = 0;
   int   n_total = 0;

   // The output bundle is {fu_init, fu_disable, busy, done, err, iter_cnt}.
   function automatic logic [23:0] pk(input logic i, input logic [3:0] d, input logic b,
                                      input logic dn, input logic e, input logic [15:0] c);
      return {i, d, b, dn, e, c};
   endfunction

   function automatic logic [23:0] a_out();
      return {a_fu_init, a_fu_disable, a_busy, a_done, a_err, a_iter};
   endfunction

   function automatic void add(input logic s, input logic a, input logic st,
                               input logic [15:0] len, input logic [3:0] m,
                               input logic [23:0] exp);
      vec_t v;
      v.start = s; v.abort = a; v.stall = st; v.len = len; v.mask = m; v.exp = exp;
      tbl.push_back(v);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
   endtask

   task automatic step(input logic s, input logic a, input logic st,
                       input logic [15:0] len, input logic [3:0] m);
      @(negedge clk);
      a_start = s; a_abort = a; a_stall = st; a_len = len; a_mask = m;
      @(posedge clk);
      #1;
      $display("t=%0t start=%b abort=%b stall=%b len=%0d mask=%h -> init=%b dis=%h busy=%b done=%b err=%b cnt=%0d",
               $time, s, a, st, len, m, a_fu_init, a_fu_disable, a_busy, a_done, a_err, a_iter);
   endtask

   initial begin
      int inits, ens, first_en, seen_done, done_iter;

      // Reset: the outputs must take their reset values before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("reset_async_a", {8'h0, a_out()}, {8'h0, pk(0, 4'hF, 0, 0, 0, 16'd0)});
      check("reset_async_b", {23'h0, b_fu_init, b_fu_disable, b_busy, b_done, b_err, b_iter},
            {23'h0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0});
      repeat (2) @(posedge clk);
      #1;
      check("reset_held_a", {8'h0, a_out()}, {8'h0, pk(0, 4'hF, 0, 0, 0, 16'd0)});
      @(negedge clk) rst_n = 1'b1;

      // Basic run: len=3, mask=0101.
      add(1, 0, 0, 16'd3, 4'h5, pk(1, 4'hF, 1, 0, 0, 16'd0)); // cycle 1: INIT
      add(0, 0, 0, 16'd3, 4'h5, pk(0, 4'hA, 1, 0, 0, 16'd0)); // cycle 2: enabled
      add(0, 0, 0, 16'd3, 4'h5, pk(0, 4'hA, 1, 0, 0, 16'd1));
      add(0, 0, 0, 16'd3, 4'h5, pk(0, 4'hA, 1, 0, 0, 16'd2)); // cycle 4
      add(0, 0, 0, 16'd3, 4'h5, pk(0, 4'hF, 1, 0, 0, 16'd3)); // cycle 5: drain
      add(0, 0, 0, 16'd3, 4'h5, pk(0, 4'hF, 1, 0, 0, 16'd3)); // cycle 6: drain
      add(0, 0, 0, 16'd3, 4'h5, pk(0, 4'hF, 0, 1, 0, 16'd3)); // cycle 7: done
      add(0, 0, 0, 16'd3, 4'h5, pk(0, 4'hF, 0, 0, 0, 16'd3)); // idle, count held
      // A zero length is rejected with err. A start that comes with abort is
      // rejected silently.
      add(1, 0, 0, 16'd0, 4'h5, pk(0, 4'hF, 0, 0, 1, 16'd3));
      add(0, 0, 0, 16'd0, 4'h5, pk(0, 4'hF, 0, 0, 0, 16'd3));
      add(1, 1, 0, 16'd5, 4'h5, pk(0, 4'hF, 0, 0, 0, 16'd3));
      // Stall run: len=4, mask=0011. RUN cycles 2 and 3 are stalled.
      // A start with len=2 during RUN is ignored.
      add(1, 0, 0, 16'd4, 4'h3, pk(1, 4'hF, 1, 0, 0, 16'd0));
      add(0, 0, 0, 16'd4, 4'h3, pk(0, 4'hC, 1, 0, 0, 16'd0)); // RUN 1 enabled
      add(0, 0, 1, 16'd4, 4'h3, pk(0, 4'hF, 1, 0, 0, 16'd1)); // RUN 2 stalled
      add(0, 0, 1, 16'd4, 4'h3, pk(0, 4'hF, 1, 0, 0, 16'd1)); // RUN 3 stalled
      add(1, 0, 0, 16'd2, 4'hF, pk(0, 4'hC, 1, 0, 0, 16'd1)); // RUN 4, start ignored
      add(0, 0, 0, 16'd2, 4'hF, pk(0, 4'hC, 1, 0, 0, 16'd2)); // RUN 5
      add(0, 0, 0, 16'd2, 4'hF, pk(0, 4'hC, 1, 0, 0, 16'd3)); // RUN 6
      add(0, 0, 0, 16'd2, 4'hF, pk(0, 4'hF, 1, 0, 0, 16'd4)); // drain
      add(0, 0, 0, 16'd2, 4'hF, pk(0, 4'hF, 1, 0, 0, 16'd4));
      add(0, 0, 0, 16'd2, 4'hF, pk(0, 4'hF, 0, 1, 0, 16'd4)); // done
      add(0, 0, 0, 16'd2, 4'hF, pk(0, 4'hF, 0, 0, 0, 16'd4));
      // All-zero mask: units stay disabled, but the count still advances.
      add(1, 0, 0, 16'd2, 4'h0, pk(1, 4'hF, 1, 0, 0, 16'd0));
      add(0, 0, 0, 16'd2, 4'h0, pk(0, 4'hF, 1, 0, 0, 16'd0));
      add(0, 0, 0, 16'd2, 4'h0, pk(0, 4'hF, 1, 0, 0, 16'd1));
      add(0, 0, 0, 16'd2, 4'h0, pk(0, 4'hF, 1, 0, 0, 16'd2));
      add(0, 0, 0, 16'd2, 4'h0, pk(0, 4'hF, 1, 0, 0, 16'd2));
      add(0, 0, 0, 16'd2, 4'h0, pk(0, 4'hF, 0, 1, 0, 16'd2));
      add(0, 0, 0, 16'd2, 4'h0, pk(0, 4'hF, 0, 0, 0, 16'd2));

      foreach (tbl[k]) begin
         step(tbl[k].start, tbl[k].abort, tbl[k].stall, tbl[k].len, tbl[k].mask);
         check($sformatf("vec%0d", k), {8'h0, a_out()}, {8'h0, tbl[k].exp});
      end

      // Abort during the 5th RUN cycle of a len=10 run.
      step(1, 0, 0, 16'd10, 4'h5);
      check("abort_init", {8'h0, a_out()}, {8'h0, pk(1, 4'hF, 1, 0, 0, 16'd0)});
      for (int r = 1; r <= 5; r++) step(0, 0, 0, 16'd10, 4'h5);
      check("abort_run5", {8'h0, a_out()}, {8'h0, pk(0, 4'hA, 1, 0, 0, 16'd4)});
      step(0, 1, 0, 16'd10, 4'h5);
      check("abort_idle", {8'h0, a_out()}, {8'h0, pk(0, 4'hF, 0, 0, 0, 16'd4)});
      for (int r = 0; r < 4; r++) begin
         step(0, 0, 0, 16'd10, 4'h5);
         check($sformatf("abort_after%0d", r), {8'h0, a_out()}, {8'h0, pk(0, 4'hF, 0, 0, 0, 16'd4)});
      end

      // Reset asserted mid-RUN, between clock edges. A new len=1 run follows.
      step(1, 0, 0, 16'd10, 4'h5);
      for (int r = 0; r < 3; r++) step(0, 0, 0, 16'd10, 4'h5);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_reset", {8'h0, a_out()}, {8'h0, pk(0, 4'hF, 0, 0, 0, 16'd0)});
      @(negedge clk) rst_n = 1'b1;
      step(1, 0, 0, 16'd1, 4'h9);
      check("post_reset_init", {8'h0, a_out()}, {8'h0, pk(1, 4'hF, 1, 0, 0, 16'd0)});
      step(0, 0, 0, 16'd1, 4'h9);
      check("post_reset_run", {8'h0, a_out()}, {8'h0, pk(0, 4'h6, 1, 0, 0, 16'd0)});
      step(0, 0, 0, 16'd1, 4'h9);
      check("post_reset_drain0", {8'h0, a_out()}, {8'h0, pk(0, 4'hF, 1, 0, 0, 16'd1)});
      step(0, 0, 0, 16'd1, 4'h9);
      check("post_reset_drain1", {8'h0, a_out()}, {8'h0, pk(0, 4'hF, 1, 0, 0, 16'd1)});
      step(0, 0, 0, 16'd1, 4'h9);
      check("post_reset_done", {8'h0, a_out()}, {8'h0, pk(0, 4'hF, 0, 1, 0, 16'd1)});

      // CNT_W=4, INIT_CYC=3, len=15. The count must reach 15 without wrapping.
      @(negedge clk);
      b_start = 1'b1; b_len = 4'd15; b_mask = 4'hF;
      @(posedge clk);
      #1;
      b_start = 1'b0;
      inits = 0; ens = 0; first_en = -1; seen_done = 0; done_iter = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (b_fu_init) inits++;
         if (b_fu_disable == 4'h0) begin
            ens++;
            if (first_en < 0) first_en = cyc;
         end
         if (b_done) begin
            seen_done = 1;
            done_iter = int'(b_iter);
            break;
         end
         @(posedge clk);
         #1;
      end
      $display("narrow run: init_cycles=%0d enabled=%0d first_en=%0d done=%0d cnt=%0d",
               inits, ens, first_en, seen_done, done_iter);
      check("narrow_done_seen", seen_done, 1);
      check("narrow_init_cycles", inits, 3);
      check("narrow_first_enabled", first_en, 4);
      check("narrow_enabled", ens, 15);
      check("narrow_iter_final", done_iter, 15);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
